// File: rtl/bp_polar_pkg.sv
// Shared types and arithmetic for the belief-propagation polar decoder:
// FSM state encoding, saturating add and the min-sum check function.
package bp_polar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2,
      ST_DONE  = 2'd3
   } bp_state_e;

   // Largest message magnitude; the range is kept symmetric so negation never overflows.
   function automatic int max_mag(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_add(input int a, input int b, input int w);
      int sum;
      int lim;
      int res;
      lim = max_mag(w);
      sum = a + b;
      if (sum > lim) begin
         res = lim;
      end else if (sum < -lim) begin
         res = -lim;
      end else begin
         res = sum;
      end
      return res;
   endfunction

   function automatic int f_minsum(input int x, input int y);
      int ax;
      int ay;
      int m;
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      m  = (ax < ay) ? ax : ay;
      return ((x < 0) != (y < 0)) ? -m : m;
   endfunction

endpackage

// File: rtl/bp_polar_pe.sv
// Combinational 2x2 butterfly processing element: produces both left-going
// and right-going messages for one node pair of the current stage.
module bp_polar_pe
   import bp_polar_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] la_in,
   input  logic [W-1:0] lb_in,
   input  logic [W-1:0] ra_in,
   input  logic [W-1:0] rb_in,
   output logic [W-1:0] la_out,
   output logic [W-1:0] lb_out,
   output logic [W-1:0] ra_out,
   output logic [W-1:0] rb_out
);

   int la_i;
   int lb_i;
   int ra_i;
   int rb_i;
   int sum_b;
   int f_a;

   always_comb begin
      la_i   = int'($signed(la_in));
      lb_i   = int'($signed(lb_in));
      ra_i   = int'($signed(ra_in));
      rb_i   = int'($signed(rb_in));
      // Both a-side outputs see the b node's combined belief; both b-side outputs see f(Ra, La).
      sum_b  = sat_add(lb_i, rb_i, W);
      f_a    = f_minsum(ra_i, la_i);
      la_out = W'(f_minsum(la_i, sum_b));
      lb_out = W'(sat_add(f_a, lb_i, W));
      ra_out = W'(f_minsum(ra_i, sum_b));
      rb_out = W'(sat_add(f_a, rb_i, W));
   end

endmodule

// File: rtl/bp_polar_decoder_param.sv
// Parametrised min-sum BP polar decoder, one butterfly stage per cycle.
// Optional early termination on a stable hard-decision vector: BP_POLAR_EARLY_STOP_EN.
module bp_polar_decoder_param
   import bp_polar_pkg::*;
#(
   parameter int LOG_N  = 3,
   parameter int W      = 8,
   parameter int ITER_W = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [(1<<LOG_N)*W-1:0] llr_in,
   input  logic [(1<<LOG_N)-1:0] frozen_mask,
   input  logic [ITER_W-1:0]     max_iter,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<LOG_N)-1:0] dec_bits,
   output logic [ITER_W-1:0]     iter_count
);

   localparam int N    = 1 << LOG_N;
   localparam int NP   = N / 2;
   localparam int CW   = $clog2(LOG_N + 1);
   localparam int MAXV = max_mag(W);
   localparam logic [W-1:0] MAX_W   = W'(MAXV);
   localparam logic [W-1:0] NEG_MAX = W'(-MAXV);
   localparam logic [W-1:0] MIN_RAW = {1'b1, {(W-1){1'b0}}};
   localparam logic [CW-1:0] TOP_STAGE = CW'(LOG_N - 1);

   bp_state_e         state;
   logic [CW-1:0]     stage;
   logic [CW-1:0]     s_up;
   int                s_int;
   logic [ITER_W-1:0] iter_cnt;
   logic [ITER_W-1:0] iter_lim;
   logic [ITER_W:0]   iter_nxt;
   logic [N-1:0]      frozen_q;
   logic [N-1:0]      hard_vec;
   logic              early_hit;

   logic [W-1:0] l_msg [N][LOG_N+1];
   logic [W-1:0] r_msg [N][LOG_N+1];
   logic [W-1:0] l_nxt [N][LOG_N+1];
   logic [W-1:0] r_nxt [N][LOG_N+1];

   logic [LOG_N-1:0] a_idx [NP];
   logic [LOG_N-1:0] b_idx [NP];
   logic [W-1:0] pe_la [NP];
   logic [W-1:0] pe_lb [NP];
   logic [W-1:0] pe_ra [NP];
   logic [W-1:0] pe_rb [NP];
   logic [W-1:0] o_la  [NP];
   logic [W-1:0] o_lb  [NP];
   logic [W-1:0] o_ra  [NP];
   logic [W-1:0] o_rb  [NP];

   function automatic logic [W-1:0] clamp_llr(input logic [W-1:0] x);
      return (x == MIN_RAW) ? NEG_MAX : x;
   endfunction

   assign s_int    = int'(stage);
   assign s_up     = stage + CW'(1);
   assign iter_nxt = {1'b0, iter_cnt} + (ITER_W+1)'(1);

   // PE p handles node a = p with a zero inserted at bit s, and its partner b = a + 2^s.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         a_idx[p] = LOG_N'(((p >> s_int) << (s_int + 1)) | (p & ((1 << s_int) - 1)));
         b_idx[p] = LOG_N'((((p >> s_int) << (s_int + 1)) | (p & ((1 << s_int) - 1)))
                           + (1 << s_int));
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_pe
      assign pe_la[p] = l_msg[a_idx[p]][s_up];
      assign pe_lb[p] = l_msg[b_idx[p]][s_up];
      assign pe_ra[p] = r_msg[a_idx[p]][stage];
      assign pe_rb[p] = r_msg[b_idx[p]][stage];

      bp_polar_pe #(.W(W)) u_pe (
         .la_in  (pe_la[p]),
         .lb_in  (pe_lb[p]),
         .ra_in  (pe_ra[p]),
         .rb_in  (pe_rb[p]),
         .la_out (o_la[p]),
         .lb_out (o_lb[p]),
         .ra_out (o_ra[p]),
         .rb_out (o_rb[p])
      );
   end

   always_comb begin
      for (int j = 0; j < N; j++) begin
         hard_vec[j] = l_msg[j][0][W-1] & ~frozen_q[j];
      end
   end

`ifdef BP_POLAR_EARLY_STOP_EN
   logic [N-1:0] snap_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_q <= '0;
      end else if (state == ST_RIGHT && stage == TOP_STAGE) begin
         snap_q <= hard_vec;
      end
   end

   assign early_hit = (iter_nxt >= (ITER_W+1)'(2)) && (hard_vec == snap_q);
`else
   assign early_hit = 1'b0;
`endif

   // Message storage next-state: LEFT writes column s of L, RIGHT writes column s+1 of R.
   always_comb begin
      l_nxt = l_msg;
      r_nxt = r_msg;
      if (!rst_n) begin
         for (int j = 0; j < N; j++) begin
            for (int c = 0; c <= LOG_N; c++) begin
               l_nxt[j][c] = '0;
               r_nxt[j][c] = '0;
            end
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  for (int j = 0; j < N; j++) begin
                     for (int c = 0; c <= LOG_N; c++) begin
                        l_nxt[j][c] = '0;
                        r_nxt[j][c] = '0;
                     end
                     l_nxt[j][LOG_N] = clamp_llr(llr_in[j*W +: W]);
                     r_nxt[j][0]     = frozen_mask[j] ? MAX_W : '0;
                  end
               end
            end
            ST_LEFT: begin
               for (int p = 0; p < NP; p++) begin
                  l_nxt[a_idx[p]][stage] = o_la[p];
                  l_nxt[b_idx[p]][stage] = o_lb[p];
               end
            end
            ST_RIGHT: begin
               for (int p = 0; p < NP; p++) begin
                  r_nxt[a_idx[p]][s_up] = o_ra[p];
                  r_nxt[b_idx[p]][s_up] = o_rb[p];
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      l_msg <= l_nxt;
      r_msg <= r_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         stage      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dec_bits   <= '0;
         iter_count <= '0;
         iter_cnt   <= '0;
         iter_lim   <= '0;
         frozen_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  stage    <= TOP_STAGE;
                  iter_cnt <= '0;
                  iter_lim <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                  frozen_q <= frozen_mask;
                  busy     <= 1'b1;
                  state    <= ST_LEFT;
               end
            end
            ST_LEFT: begin
               if (stage == '0) begin
                  state <= ST_RIGHT;
               end else begin
                  stage <= stage - CW'(1);
               end
            end
            ST_RIGHT: begin
               if (stage == TOP_STAGE) begin
                  iter_cnt <= iter_nxt[ITER_W-1:0];
                  if (iter_nxt >= {1'b0, iter_lim} || early_hit) begin
                     busy  <= 1'b0;
                     state <= ST_DONE;
                  end else begin
                     stage <= TOP_STAGE;
                     state <= ST_LEFT;
                  end
               end else begin
                  stage <= stage + CW'(1);
               end
            end
            ST_DONE: begin
               done       <= 1'b1;
               dec_bits   <= hard_vec;
               iter_count <= iter_cnt;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_polar_decoder_param.sv
// Bench for bp_polar_decoder_param (LOG_N=3, W=8): directed decodes checked
// against a behavioural BP model, plus literal expectations for key cases.
module tb_bp_polar_decoder_param;

   localparam int LOG_N  = 3;
   localparam int N      = 8;
   localparam int W      = 8;
   localparam int ITER_W = 7;
   localparam int MAXV   = 127;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [N*W-1:0]    llr_in;
   logic [N-1:0]      frozen_mask;
   logic [ITER_W-1:0] max_iter;
   logic              busy;
   logic              done;
   logic [N-1:0]      dec_bits;
   logic [ITER_W-1:0] iter_count;

   bp_polar_decoder_param #(.LOG_N(LOG_N), .W(W), .ITER_W(ITER_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .llr_in      (llr_in),
      .frozen_mask (frozen_mask),
      .max_iter    (max_iter),
      .busy        (busy),
      .done        (done),
      .dec_bits    (dec_bits),
      .iter_count  (iter_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_seen = 0;
   int start_cyc = 0;
   int last_lat = 0;
   int last_dec = 0;
   int last_iter = 0;

   logic [N-1:0] exp_q[$];
   int exp_iter_q[$];
   int exp_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > MAXV) return MAXV;
      if (v < -MAXV) return -MAXV;
      return v;
   endfunction

   function automatic int fmin(input int x, input int y);
      int ax;
      int ay;
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      if (ay < ax) ax = ay;
      return ((x < 0) != (y < 0)) ? -ax : ax;
   endfunction

   // Plain BP iteration on integer arrays: full left sweep then full right sweep.
   task automatic model(input logic [N*W-1:0] llr, input logic [N-1:0] mask, input int maxit,
                        output logic [N-1:0] dec, output int iters);
      int lm [N][LOG_N+1];
      int rm [N][LOG_N+1];
      logic [N-1:0] hv;
      logic [N-1:0] prev;
      int lim;
      int v;
      int b;
      int t0;
      int t1;
      bit stop;
      lim = (maxit == 0) ? 1 : maxit;
      for (int j = 0; j < N; j++) begin
         for (int c = 0; c <= LOG_N; c++) begin
            lm[j][c] = 0;
            rm[j][c] = 0;
         end
         v = $signed(llr[j*W +: W]);
         if (v < -MAXV) v = -MAXV;
         lm[j][LOG_N] = v;
         rm[j][0] = mask[j] ? MAXV : 0;
      end
      iters = 0;
      prev = '0;
      hv = '0;
      stop = 0;
      while (!stop) begin
         for (int s = LOG_N - 1; s >= 0; s--) begin
            for (int a = 0; a < N; a++) begin
               if (((a >> s) & 1) == 0) begin
                  b = a + (1 << s);
                  t0 = fmin(lm[a][s+1], sat(lm[b][s+1] + rm[b][s]));
                  t1 = sat(fmin(rm[a][s], lm[a][s+1]) + lm[b][s+1]);
                  lm[a][s] = t0;
                  lm[b][s] = t1;
               end
            end
         end
         for (int s = 0; s < LOG_N; s++) begin
            for (int a = 0; a < N; a++) begin
               if (((a >> s) & 1) == 0) begin
                  b = a + (1 << s);
                  t0 = fmin(rm[a][s], sat(lm[b][s+1] + rm[b][s]));
                  t1 = sat(fmin(rm[a][s], lm[a][s+1]) + rm[b][s]);
                  rm[a][s+1] = t0;
                  rm[b][s+1] = t1;
               end
            end
         end
         iters++;
         for (int j = 0; j < N; j++) hv[j] = (lm[j][0] < 0) && !mask[j];
`ifdef BP_POLAR_EARLY_STOP_EN
         if (iters >= 2 && hv == prev) stop = 1;
`endif
         prev = hv;
         if (iters >= lim) stop = 1;
      end
      dec = hv;
   endtask

   function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
      return {N{v}};
   endfunction

   // Compare process: every done pulse is matched to the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_seen++;
         last_lat  = cyc - start_cyc;
         last_dec  = int'(dec_bits);
         last_iter = int'(iter_count);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            check("dec_bits", int'(dec_bits), int'(exp_q.pop_front()));
            check("iter_count", int'(iter_count), exp_iter_q.pop_front());
            check("done_cycle", cyc, exp_cyc_q.pop_front());
            check("busy_at_done", int'(busy), 0);
         end
      end
   end

   task automatic launch(input logic [N*W-1:0] llr, input logic [N-1:0] mask, input int maxit);
      logic [N-1:0] d;
      int it;
      model(llr, mask, maxit, d, it);
      @(negedge clk);
      llr_in = llr;
      frozen_mask = mask;
      max_iter = ITER_W'(maxit);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start_cyc = cyc;
      exp_q.push_back(d);
      exp_iter_q.push_back(it);
      exp_cyc_q.push_back(start_cyc + 2 * LOG_N * it + 1);
      check("busy_after_start", int'(busy), 1);
   endtask

   task automatic wait_done(input int base);
      int k;
      k = 0;
      while (done_seen == base && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (done_seen == base) check("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic run(input logic [N*W-1:0] llr, input logic [N-1:0] mask, input int maxit);
      int base;
      base = done_seen;
      launch(llr, mask, maxit);
      wait_done(base);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] md;
      int mi;
      int base;

      rst_n = 1'b0;
      start = 1'b0;
      llr_in = '0;
      frozen_mask = '0;
      max_iter = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_dec", int'(dec_bits), 0);
      check("reset_iter", int'(iter_count), 0);
      rst_n = 1'b1;

      // Pin the model with hand-derived results.
      model(rep(8'd32), 8'h17, 40, md, mi);
      check("model_zero_dec", int'(md), 0);
`ifdef BP_POLAR_EARLY_STOP_EN
      check("model_zero_iter", mi, 2);
`else
      check("model_zero_iter", mi, 40);
`endif
      model(rep(8'hE0), 8'h17, 10, md, mi);
      check("model_u7_dec", int'(md), 8'h80);
      model(rep(8'd32), 8'h17, 0, md, mi);
      check("model_iter0", mi, 1);

      // All-zero codeword.
      run(rep(8'd32), 8'h17, 40);
      check("t1_dec", last_dec, 0);
`ifdef BP_POLAR_EARLY_STOP_EN
      check("t6_iter", last_iter, 2);
      check("t6_latency", last_lat, 13);
`else
      check("t1_iter", last_iter, 40);
      check("t1_latency", last_lat, 241);
`endif

      // u7 = 1, channel word all ones.
      run(rep(8'hE0), 8'h17, 10);
      check("t2_dec", last_dec, 8'h80);
`ifndef BP_POLAR_EARLY_STOP_EN
      check("t2_iter", last_iter, 10);
      check("t2_latency", last_lat, 61);
`endif

      // Reset in the middle of a decode, with dec_bits non-zero from the previous run.
      launch(rep(8'd32), 8'h17, 40);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_busy", int'(busy), 0);
      check("midreset_done", int'(done), 0);
      check("midreset_dec", int'(dec_bits), 0);
      check("midreset_iter", int'(iter_count), 0);
      rst_n = 1'b1;
      exp_q.delete();
      exp_iter_q.delete();
      exp_cyc_q.delete();
      run(rep(8'hE0), 8'h17, 10);
      check("after_reset_dec", last_dec, 8'h80);

      // Saturated inputs, including the most negative code.
      run(rep(8'h7F), 8'h17, 5);
      check("t3_pos_dec", last_dec, 0);
      run(rep(8'h80), 8'h17, 5);
      check("t3_neg_dec", last_dec, 8'h80);

      // max_iter of zero runs a single iteration.
      run(rep(8'd32), 8'h17, 0);
      check("t4_iter", last_iter, 1);
      check("t4_latency", last_lat, 7);

      // Start pulsed while busy must not trigger a second decode.
      base = done_seen;
      launch(rep(8'd32), 8'h17, 3);
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(base);
      repeat (30) @(negedge clk);
      check("single_done", done_seen - base, 1);

      // Noisy mixed-sign channel word.
      run({8'd15, 8'd10, 8'd25, 8'hFE, 8'd3, 8'd30, 8'hFB, 8'd20}, 8'h17, 8);
      run({8'hF0, 8'd12, 8'hE8, 8'd6, 8'hF6, 8'd9, 8'hEC, 8'd2}, 8'h03, 6);

      repeat (5) @(negedge clk);
      check("leftover_expectations", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
